// File: rtl/trap_controller.sv
// Machine-mode trap/return controller: owns the trap CSRs, sequences
// flush -> redirect on exception, external interrupt or MRET.
package trap_pkg;
    typedef enum logic [1:0] {
        SYSOP_NORMAL = 2'd0,
        SYSOP_ECALL  = 2'd1,
        SYSOP_EBREAK = 2'd2,
        SYSOP_MRET   = 2'd3
    } sysop_mode_t;
endpackage

module trap_controller
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic [XLEN-1:0]   commit_next_pc,
    input  logic [31:0]       commit_instr,
    input  sysop_mode_t       commit_sysop,
    input  logic              commit_illegal,
    input  logic              irq_ext,
    input  logic [11:0]       csr_addr,
    input  logic              csr_we,
    input  logic [XLEN-1:0]   csr_wdata,
    output logic [XLEN-1:0]   csr_rdata,
    output logic              busy,
    output logic              flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);
    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIR} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_mie, r_mpie, r_meie;
    logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause, r_mtval, r_target;

    logic w_accept, w_exc, w_irq, w_trap, w_mret, w_wr;

    assign w_accept = (r_state == S_IDLE) && commit_valid;
    assign w_exc    = commit_illegal || (commit_sysop == SYSOP_ECALL) ||
                      (commit_sysop == SYSOP_EBREAK);
    // Interrupt rides on an ordinary, non-writing commit so the instruction can retire.
    assign w_irq    = r_mie && r_meie && irq_ext && !commit_illegal &&
                      (commit_sysop == SYSOP_NORMAL) && !csr_we;
    assign w_trap   = w_accept && (w_exc || w_irq);
    assign w_mret   = w_accept && !commit_illegal && (commit_sysop == SYSOP_MRET);
    assign w_wr     = w_accept && csr_we && !w_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_trap || w_mret) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_REDIR;
            S_REDIR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_meie   <= 1'b0;
            r_mtvec  <= RESET_MTVEC;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_target <= '0;
        end else begin
            if (w_wr) begin
                case (csr_addr)
                    12'h300: begin r_mie <= csr_wdata[3]; r_mpie <= csr_wdata[7]; end
                    12'h304: r_meie   <= csr_wdata[11];
                    12'h305: r_mtvec  <= {csr_wdata[XLEN-1:2], 2'b00};
                    12'h341: r_mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                    12'h342: r_mcause <= csr_wdata;
                    12'h343: r_mtval  <= csr_wdata;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
                r_target <= {r_mtvec[XLEN-1:2], 2'b00};
                if (commit_illegal) begin
                    r_mcause <= XLEN'(2);
                    r_mtval  <= XLEN'(commit_instr);
                    r_mepc   <= {commit_pc[XLEN-1:2], 2'b00};
                end else if (commit_sysop == SYSOP_EBREAK) begin
                    r_mcause <= XLEN'(3);
                    r_mtval  <= commit_pc;
                    r_mepc   <= {commit_pc[XLEN-1:2], 2'b00};
                end else if (commit_sysop == SYSOP_ECALL) begin
                    r_mcause <= XLEN'(11);
                    r_mtval  <= '0;
                    r_mepc   <= {commit_pc[XLEN-1:2], 2'b00};
                end else begin
                    r_mcause <= IRQ_CAUSE;
                    r_mtval  <= '0;
                    r_mepc   <= {commit_next_pc[XLEN-1:2], 2'b00};
                end
            end else if (w_mret) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
                r_target <= r_mepc;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: begin
                csr_rdata[12:11] = 2'b11;
                csr_rdata[7]     = r_mpie;
                csr_rdata[3]     = r_mie;
            end
            12'h304: csr_rdata[11] = r_meie;
            12'h305: csr_rdata     = r_mtvec;
            12'h341: csr_rdata     = r_mepc;
            12'h342: csr_rdata     = r_mcause;
            12'h343: csr_rdata     = r_mtval;
            12'h344: csr_rdata[11] = irq_ext;
            default: ;
        endcase
    end

    assign busy           = (r_state != S_IDLE);
    assign flush          = (r_state == S_FLUSH);
    assign redirect_valid = (r_state == S_REDIR);
    assign redirect_pc    = r_target;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: CSR access, exception/interrupt entry,
// MRET return, busy-time input masking and mid-sequence reset.
module tb_trap_controller;
    import trap_pkg::*;

    localparam logic [31:0] RST_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0, commit_next_pc = '0, commit_instr = '0;
    sysop_mode_t commit_sysop = SYSOP_NORMAL;
    logic        commit_illegal = 1'b0;
    logic        irq_ext = 1'b0;
    logic [11:0] csr_addr = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        busy, flush, redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    trap_controller #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_next_pc(commit_next_pc), .commit_instr(commit_instr),
        .commit_sysop(commit_sysop), .commit_illegal(commit_illegal), .irq_ext(irq_ext),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .busy(busy), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        csr_addr = a; #1; v = csr_rdata;
    endtask

    // Presents one commit for a single cycle; returns 1ns after that edge.
    task automatic commit(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] ins,
                          input sysop_mode_t op, input logic ill, input logic we,
                          input logic [11:0] a, input logic [31:0] wd);
        commit_pc = pc; commit_next_pc = npc; commit_instr = ins; commit_sysop = op;
        commit_illegal = ill; csr_we = we; csr_addr = a; csr_wdata = wd; commit_valid = 1'b1;
        step();
        commit_valid = 1'b0; csr_we = 1'b0; commit_sysop = SYSOP_NORMAL; commit_illegal = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        commit(32'h1000, 32'h1004, 32'h13, SYSOP_NORMAL, 1'b0, 1'b1, a, d);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; step(); step();
        n_tests++; if ({busy, flush, redirect_valid} !== 3'b000 || redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_strobes got b/f/r=%b%b%b pc=%h want 000 pc=0", busy, flush, redirect_valid, redirect_pc); end
        rst = 1'b0; step();
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus got %h want 00001800", v); end
        rd(12'h304, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mie got %h want 0", v); end
        rd(12'h305, v); n_tests++; if (v !== RST_VEC) begin n_fail++; $display("FAIL reset_mtvec got %h want %h", v, RST_VEC); end
        rd(12'h341, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got %h want 0", v); end
        rd(12'h342, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mcause got %h want 0", v); end
        rd(12'h343, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mtval got %h want 0", v); end
        rd(12'h344, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mip got %h want 0", v); end
    endtask

    task automatic test_csr_rw();
        logic [31:0] v;
        csr_write(12'h341, 32'h0000_0207);
        rd(12'h341, v); n_tests++; if (v !== 32'h0000_0204) begin n_fail++; $display("FAIL mepc_align got %h want 00000204", v); end
        csr_write(12'h340, 32'hDEAD_BEEF);
        rd(12'h340, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h want 0", v); end
        csr_write(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mstatus_mask got %h want 00001888", v); end
        csr_write(12'h300, 32'h0);
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL mstatus_clr got %h want 00001800", v); end
    endtask

    task automatic test_ecall();
        logic [31:0] v;
        csr_write(12'h305, 32'h0000_0103);
        rd(12'h305, v); n_tests++; if (v !== 32'h0000_0100) begin n_fail++; $display("FAIL mtvec_align got %h want 00000100", v); end
        csr_write(12'h300, 32'h0000_0008);
        commit(32'h100, 32'h104, 32'h73, SYSOP_ECALL, 1'b0, 1'b0, 12'h0, 32'h0);
        n_tests++; if ({busy, flush, redirect_valid} !== 3'b110) begin
            n_fail++; $display("FAIL ecall_n1 got b/f/r=%b%b%b want 110", busy, flush, redirect_valid); end
        rd(12'h341, v); n_tests++; if (v !== 32'h100) begin n_fail++; $display("FAIL ecall_mepc got %h want 00000100", v); end
        rd(12'h342, v); n_tests++; if (v !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause got %h want 0000000b", v); end
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL ecall_mstatus got %h want 00001880", v); end
        step();
        n_tests++; if ({busy, flush, redirect_valid} !== 3'b101 || redirect_pc !== 32'h100) begin
            n_fail++; $display("FAIL ecall_n2 got b/f/r=%b%b%b pc=%h want 101 pc=00000100", busy, flush, redirect_valid, redirect_pc); end
        step();
        n_tests++; if ({busy, flush, redirect_valid} !== 3'b000) begin
            n_fail++; $display("FAIL ecall_n3 got b/f/r=%b%b%b want 000", busy, flush, redirect_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        commit(32'h200, 32'h204, 32'hFFFF_FFFF, SYSOP_EBREAK, 1'b1, 1'b0, 12'h0, 32'h0);
        rd(12'h342, v); n_tests++; if (v !== 32'd2) begin n_fail++; $display("FAIL ill_mcause got %h want 00000002", v); end
        rd(12'h343, v); n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ill_mtval got %h want ffffffff", v); end
        rd(12'h341, v); n_tests++; if (v !== 32'h200) begin n_fail++; $display("FAIL ill_mepc got %h want 00000200", v); end
        step(); step();
        commit(32'h300, 32'h304, 32'h0010_0073, SYSOP_EBREAK, 1'b0, 1'b0, 12'h0, 32'h0);
        rd(12'h342, v); n_tests++; if (v !== 32'd3) begin n_fail++; $display("FAIL ebreak_mcause got %h want 00000003", v); end
        rd(12'h343, v); n_tests++; if (v !== 32'h300) begin n_fail++; $display("FAIL ebreak_mtval got %h want 00000300", v); end
        step();
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
            n_fail++; $display("FAIL ebreak_redir got rv=%b pc=%h want 1 00000100", redirect_valid, redirect_pc); end
        step();
    endtask

    task automatic test_irq();
        logic [31:0] v;
        csr_write(12'h300, 32'h0000_0008);
        csr_write(12'h304, 32'h0000_0800);
        irq_ext = 1'b1;
        rd(12'h344, v); n_tests++; if (v !== 32'h800) begin n_fail++; $display("FAIL mip_level got %h want 00000800", v); end
        csr_write(12'h343, 32'h55);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL irq_defer got busy=%b want 0", busy); end
        rd(12'h343, v); n_tests++; if (v !== 32'h55) begin n_fail++; $display("FAIL irq_defer_wr got %h want 00000055", v); end
        commit(32'h400, 32'h404, 32'h13, SYSOP_NORMAL, 1'b0, 1'b0, 12'h0, 32'h0);
        irq_ext = 1'b0;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL irq_flush got %b want 1", flush); end
        rd(12'h342, v); n_tests++; if (v !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_mcause got %h want 8000000b", v); end
        rd(12'h341, v); n_tests++; if (v !== 32'h404) begin n_fail++; $display("FAIL irq_mepc got %h want 00000404", v); end
        rd(12'h343, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL irq_mtval got %h want 0", v); end
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL irq_mstatus got %h want 00001880", v); end
        step(); step();
    endtask

    task automatic test_mret();
        logic [31:0] v;
        commit(32'h500, 32'h504, 32'h3020_0073, SYSOP_MRET, 1'b0, 1'b0, 12'h0, 32'h0);
        // Junk presented while busy must be ignored.
        commit_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h343; csr_wdata = 32'h99;
        commit_sysop = SYSOP_ECALL; irq_ext = 1'b1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mret_flush got %b want 1", flush); end
        step();
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h404) begin
            n_fail++; $display("FAIL mret_redir got rv=%b pc=%h want 1 00000404", redirect_valid, redirect_pc); end
        commit_valid = 1'b0; csr_we = 1'b0; commit_sysop = SYSOP_NORMAL; irq_ext = 1'b0;
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mret_idle got busy=%b want 0", busy); end
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus got %h want 00001888", v); end
        rd(12'h343, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL busy_ignore_mtval got %h want 0", v); end
        rd(12'h342, v); n_tests++; if (v !== 32'h8000_000B) begin n_fail++; $display("FAIL busy_ignore_mcause got %h want 8000000b", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        commit(32'h600, 32'h604, 32'h73, SYSOP_ECALL, 1'b0, 1'b0, 12'h0, 32'h0);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got flush=%b want 1", flush); end
        csr_addr = 12'h305;
        #2 rst = 1'b1; #1;
        n_tests++; if ({busy, flush, redirect_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_drop got b/f/r=%b%b%b want 000", busy, flush, redirect_valid); end
        n_tests++; if (csr_rdata !== RST_VEC) begin n_fail++; $display("FAIL rstmid_mtvec got %h want %h", csr_rdata, RST_VEC); end
        rst = 1'b0;
        step();
        n_tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_noredir got rv=%b busy=%b want 0 0", redirect_valid, busy); end
        rd(12'h341, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstmid_mepc got %h want 0", v); end
        rd(12'h342, v); n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstmid_mcause got %h want 0", v); end
        rd(12'h300, v); n_tests++; if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL rstmid_mstatus got %h want 00001800", v); end
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_ecall();
        test_illegal();
        test_irq();
        test_mret();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap and return controller at the commit end of the pipeline. It receives the system-operation and illegal-instruction indications produced by instruction decode, along with a level external interrupt. On a trap it updates the machine trap CSRs, flushes the pipeline for one cycle, and then issues a single-cycle PC redirect to the trap vector; on MRET it redirects to the saved return address. It also owns the CSR read/write port for the trap CSRs, used by the Zicsr datapath.

## Interface
Parameters:
- XLEN, 32, datapath/CSR width
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- commit_next_pc  in  XLEN  architectural next PC of the retiring instruction
- commit_instr  in  32  raw instruction bits
- commit_sysop  in  sysop_mode_t  SYSOP_NORMAL / SYSOP_ECALL / SYSOP_EBREAK / SYSOP_MRET
- commit_illegal  in  1  instruction is illegal
- irq_ext  in  1  external interrupt request, level
- csr_addr  in  12  CSR address
- csr_we  in  1  CSR write strobe, qualified by commit_valid
- csr_wdata  in  XLEN  CSR write data, already merged for RW/RS/RC
- csr_rdata  out  XLEN  combinational read data for csr_addr
- busy  out  1  high whenever the controller is not in IDLE
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target

## Operation
- Registered state: mstatus.MIE (bit 3), mstatus.MPIE (bit 7), mie.MEIE (bit 11), mtvec, mepc, mcause, mtval.
- mstatus reads MPP (bits 12:11) as 2'b11. All other bits read as 0 and ignore writes.
- mip at 0x344 is read-only. Bit 11 reflects irq_ext.
- CSR map: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344. Any unmapped address reads 0 and ignores writes.
- mtvec is direct mode only: bits 1:0 are written as 0. mepc bits 1:0 are written as 0.
- Trap cause is evaluated only in IDLE with commit_valid=1. Priority order:
  - commit_illegal: mcause=2, mtval=commit_instr, mepc=commit_pc
  - SYSOP_EBREAK: mcause=3, mtval=commit_pc, mepc=commit_pc
  - SYSOP_ECALL: mcause=11, mtval=0, mepc=commit_pc
  - SYSOP_MRET: no CSR trap fields written
  - External interrupt: taken when MIE & MEIE & irq_ext, the instruction is SYSOP_NORMAL and not illegal, and csr_we=0. Sets mcause=32'h8000_000B, mtval=0, mepc=commit_next_pc; the retiring instruction completes.
- Trap entry (exception or interrupt): MPIE<=MIE, MIE<=0. Target is {mtvec[XLEN-1:2],2'b00}.
- MRET: MIE<=MPIE, MPIE<=1. Target is mepc.
- CSR writes are applied only in IDLE with commit_valid & csr_we. A CSR write never coincides with a trap: an exception instruction carries no write, and the interrupt is held off while csr_we=1.
- FSM:
  - IDLE→FLUSH on any trap or MRET.
  - FLUSH→REDIRECT unconditionally.
  - REDIRECT→IDLE unconditionally.
  - The target is latched at IDLE exit.
- In FLUSH and REDIRECT, commit_valid and csr_we are ignored, and irq_ext is not sampled.

## Timing
- Reset values: state=IDLE, busy=0, flush=0, redirect_valid=0, redirect_pc=0, MIE=MPIE=MEIE=0, mepc=mcause=mtval=0, mtvec=RESET_MTVEC.
- Trigger accepted at cycle N. CSR updates are visible from N+1.
- Cycle N+1: flush=1, busy=1.
- Cycle N+2: redirect_valid=1, redirect_pc=target, busy=1, flush=0.
- Cycle N+3: IDLE, all strobes 0. The earliest next acceptance is N+3.
- csr_rdata is combinational from current register state. A write at cycle N reads back from N+1.
- irq_ext rising while busy is taken at the first eligible commit after returning to IDLE.
- rst asserted mid-sequence: immediately returns to IDLE, drops flush/redirect_valid, and restores every reset value.

## Test plan
- Reset, then read all seven CSRs → mstatus=32'h0000_1800, mtvec=RESET_MTVEC, others 0. busy=flush=redirect_valid=0.
- Write mtvec=32'h0000_0103; then ECALL at commit_pc=32'h100 → mtvec reads 32'h100. flush at N+1; redirect_valid with redirect_pc=32'h100 at N+2. mepc=32'h100, mcause=11, MIE=0.
- Commit illegal with commit_sysop=SYSOP_EBREAK and commit_instr=32'hFFFF_FFFF at pc 32'h200 → mcause=2, mtval=32'hFFFF_FFFF, mepc=32'h200.
- Set MIE=1 and MEIE=1, raise irq_ext on an ordinary commit with commit_next_pc=32'h404 → mcause=32'h8000_000B, mepc=32'h404, MPIE=1, MIE=0. The same interrupt with csr_we=1 in that cycle is deferred to the next commit.
- MRET with mepc=32'h404, MPIE=1 → redirect_pc=32'h404 at N+2, MIE=1, MPIE=1.
- Assert rst during FLUSH → flush drops immediately, no redirect follows, and CSRs return to reset values.
